// File: rtl/dm_pkg.sv
// Shared defaults and types for the data-memory responder and its write buffer.
package dm_pkg;

   localparam int DEPTH_WORDS_DEF = 1024;
   localparam int CNT_W_DEF       = 16;
   localparam int IDX_W_DEF       = $clog2(DEPTH_WORDS_DEF);

   // One-entry write buffer occupancy
   typedef enum logic [0:0] {
      WB_EMPTY   = 1'b0,
      WB_PENDING = 1'b1
   } wb_state_e;

endpackage

// File: rtl/dm_wbuf.sv
// One-entry posted write buffer with read-forwarding compare.
// A captured entry drains to RAM on the next edge unless reset discards it.
module dm_wbuf
   import dm_pkg::*;
#(
   parameter int IDX_W = IDX_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [31:0]      wr_data,
   input  logic [IDX_W-1:0] rd_idx,
   output logic             drain_en,
   output logic [IDX_W-1:0] drain_idx,
   output logic [31:0]      drain_data,
   output logic             fwd_hit,
   output logic [31:0]      fwd_data
);

   wb_state_e        state_r;
   wb_state_e        state_nxt_s;
   logic [IDX_W-1:0] idx_r;
   logic [31:0]      data_r;

   // Next-state: a new write always leaves the buffer occupied, otherwise it empties
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         WB_EMPTY: begin
            if (wr_en) state_nxt_s = WB_PENDING;
            else       state_nxt_s = WB_EMPTY;
         end
         WB_PENDING: begin
            if (wr_en) state_nxt_s = WB_PENDING;
            else       state_nxt_s = WB_EMPTY;
         end
         default: state_nxt_s = WB_EMPTY;
      endcase
   end

   // State register; reset drops any pending entry without draining it
   always_ff @(posedge clk) begin
      if (reset) state_r <= WB_EMPTY;
      else       state_r <= state_nxt_s;
   end

   // Entry capture; the old entry leaves through the drain port on the same edge
   always_ff @(posedge clk) begin
      if (wr_en) begin
         idx_r  <= wr_idx;
         data_r <= wr_data;
      end
   end

   assign drain_en   = (state_r == WB_PENDING) & ~reset;
   assign drain_idx  = idx_r;
   assign drain_data = data_r;
   assign fwd_hit    = (state_r == WB_PENDING) & (idx_r == rd_idx);
   assign fwd_data   = data_r;

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: zero-latency reads, posted writes, range/protocol
// error detection and saturating access counters.
module dm_responder
   import dm_pkg::*;
#(
   parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
   parameter int CNT_W       = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             DM_CS,
   input  logic             DM_R,
   input  logic             DM_W,
   input  logic [31:0]      maddr,
   input  logic [31:0]      mwdata,
   output logic [31:0]      mr_data,
   output logic             err,
   output logic [CNT_W-1:0] rd_count,
   output logic [CNT_W-1:0] wr_count
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   logic [31:0]      mem_r [DEPTH_WORDS];
   logic [IDX_W-1:0] idx_s;
   logic             in_range_s;
   logic             access_s;
   logic             both_s;
   logic             misalign_s;
   logic             rd_ok_s;
   logic             wr_ok_s;
   logic             err_set_s;
   logic             drain_en_s;
   logic [IDX_W-1:0] drain_idx_s;
   logic [31:0]      drain_data_s;
   logic             fwd_hit_s;
   logic [31:0]      fwd_data_s;
   logic             err_r;
   logic [CNT_W-1:0] rd_count_r;
   logic [CNT_W-1:0] wr_count_r;

   // Low two address bits select a byte and are ignored for the word access
   assign idx_s      = maddr[IDX_W+1:2];
   assign in_range_s = ((maddr >> (IDX_W + 2)) == 32'h0);
   assign access_s   = DM_CS & (DM_R | DM_W);
   assign both_s     = DM_CS & DM_R & DM_W;
   assign misalign_s = access_s & (maddr[1:0] != 2'b00);
   assign rd_ok_s    = ~reset & DM_CS & DM_R & ~DM_W & in_range_s;
   assign wr_ok_s    = ~reset & DM_CS & DM_W & ~DM_R & in_range_s;
   assign err_set_s  = ~reset & (misalign_s | both_s | (access_s & ~in_range_s));

   dm_wbuf #(
      .IDX_W (IDX_W)
   ) u_wbuf (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (wr_ok_s),
      .wr_idx     (idx_s),
      .wr_data    (mwdata),
      .rd_idx     (idx_s),
      .drain_en   (drain_en_s),
      .drain_idx  (drain_idx_s),
      .drain_data (drain_data_s),
      .fwd_hit    (fwd_hit_s),
      .fwd_data   (fwd_data_s)
   );

   // RAM array: only written by the buffer drain, never cleared
   always_ff @(posedge clk) begin
      if (drain_en_s) mem_r[drain_idx_s] <= drain_data_s;
   end

   // Read mux: a pending buffered entry for the same word wins over RAM
   always_comb begin
      mr_data = 32'h0;
      if (rd_ok_s) begin
         if (fwd_hit_s) mr_data = fwd_data_s;
         else           mr_data = mem_r[idx_s];
      end else begin
         mr_data = 32'h0;
      end
   end

   // Sticky error flag
   always_ff @(posedge clk) begin
      if (reset)          err_r <= 1'b0;
      else if (err_set_s) err_r <= 1'b1;
      else                err_r <= err_r;
   end

   // Saturating access counters
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_count_r <= {CNT_W{1'b0}};
         wr_count_r <= {CNT_W{1'b0}};
      end else begin
         if (rd_ok_s && (rd_count_r != {CNT_W{1'b1}})) rd_count_r <= rd_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
         if (wr_ok_s && (wr_count_r != {CNT_W{1'b1}})) wr_count_r <= wr_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign err      = err_r;
   assign rd_count = rd_count_r;
   assign wr_count = wr_count_r;

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: an architectural memory model produces
// the expected load data when each cycle is driven; it is popped and compared
// when mr_data is sampled on the falling edge.
module tb_dm_responder;
   import dm_pkg::*;

   localparam int CNT_W   = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             DM_CS;
   logic             DM_R;
   logic             DM_W;
   logic [31:0]      maddr;
   logic [31:0]      mwdata;
   logic [31:0]      mr_data;
   logic             err;
   logic [CNT_W-1:0] rd_count;
   logic [CNT_W-1:0] wr_count;

   dm_responder #(
      .DEPTH_WORDS (1024),
      .CNT_W       (CNT_W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .DM_CS    (DM_CS),
      .DM_R     (DM_R),
      .DM_W     (DM_W),
      .maddr    (maddr),
      .mwdata   (mwdata),
      .mr_data  (mr_data),
      .err      (err),
      .rd_count (rd_count),
      .wr_count (wr_count)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_q[$];

   // architectural model
   logic [31:0] mem_m [1024];
   int          rd_m = 0;
   int          wr_m = 0;
   logic        err_m = 1'b0;
   logic        last_wr = 1'b0;
   int          last_idx = 0;
   logic [31:0] last_old = 32'h0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc(input logic cs, input logic r, input logic w,
                      input logic [31:0] a, input logic [31:0] d, input logic rst);
      logic [31:0] e;
      logic [31:0] popped;
      int          idx;
      logic        inr;
      DM_CS = cs; DM_R = r; DM_W = w; maddr = a; mwdata = d; reset = rst;
      idx = int'(a[11:2]);
      inr = (a[31:12] == 20'h0);
      e = 32'h0;
      if (rst) begin
         // a write posted on the previous edge is discarded, never drained
         if (last_wr) mem_m[last_idx] = last_old;
         last_wr = 1'b0;
         rd_m = 0; wr_m = 0; err_m = 1'b0;
      end else begin
         last_wr = 1'b0;
         if (cs && (r || w) && (!inr || (r && w) || (a[1:0] != 2'b00))) err_m = 1'b1;
         if (cs && r && !w && inr) begin
            e = mem_m[idx];
            if (rd_m < CNT_MAX) rd_m++;
         end
         if (cs && w && !r && inr) begin
            last_old = mem_m[idx];
            last_idx = idx;
            last_wr  = 1'b1;
            mem_m[idx] = d;
            if (wr_m < CNT_MAX) wr_m++;
         end
      end
      exp_q.push_back(e);
      @(negedge clk);
      check_eq("sb_depth", exp_q.size(), 32'd1);
      if (exp_q.size() > 0) begin
         popped = exp_q.pop_front();
         check_eq("mr_data", mr_data, popped);
      end
      @(posedge clk);
      #1;
      check_eq("err", {31'h0, err}, {31'h0, err_m});
      check_eq("rd_count", {24'h0, rd_count}, rd_m);
      check_eq("wr_count", {24'h0, wr_count}, wr_m);
   endtask

   function automatic logic [31:0] waddr(input int idx);
      logic [9:0] i10;
      i10 = idx[9:0];
      return {20'h0, i10, 2'b00};
   endfunction

   task automatic wr(input int idx, input logic [31:0] d);
      cyc(1'b1, 1'b0, 1'b1, waddr(idx), d, 1'b0);
   endtask

   task automatic rd(input int idx);
      cyc(1'b1, 1'b1, 1'b0, waddr(idx), 32'h0, 1'b0);
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic rst_cyc();
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
   endtask

   initial begin
      DM_CS = 1'b0; DM_R = 1'b0; DM_W = 1'b0; maddr = 32'h0; mwdata = 32'h0; reset = 1'b1;
      for (int i = 0; i < 1024; i++) mem_m[i] = 32'h0;
      @(posedge clk);
      #1;
      rst_cyc();
      // read attempt while reset is high: ignored, returns zero
      cyc(1'b1, 1'b1, 1'b0, waddr(1), 32'h0, 1'b1);
      idle();

      // known contents for the words under test
      wr(1, 32'h1111_1111);
      wr(3, 32'h0000_0000);
      wr(5, 32'h0000_0000);
      wr(7, 32'h7777_7777);
      idle();
      rd(1);
      rd(7);

      // forward from buffer, then from RAM
      wr(3, 32'hA5A5_A5A5);
      rd(3);
      idle();
      rd(3);

      // back-to-back writes to one word
      wr(5, 32'd1);
      wr(5, 32'd2);
      wr(5, 32'd3);
      idle();
      idle();
      check_eq("fsm_empty", {31'h0, dut.u_wbuf.state_r}, {31'h0, WB_EMPTY});
      rd(5);

      // strobes without chip select: no access, no error
      cyc(1'b0, 1'b1, 1'b0, waddr(1), 32'h0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, waddr(1), 32'hFFFF_FFFF, 1'b0);
      rd(1);

      // out-of-range write
      cyc(1'b1, 1'b0, 1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 1'b0);
      idle();
      rd(1);

      // pending write discarded by reset
      wr(7, 32'h0000_1234);
      rst_cyc();
      idle();
      rd(7);

      // misaligned read of word 1
      cyc(1'b1, 1'b1, 1'b0, 32'h0000_0006, 32'h0, 1'b0);
      rst_cyc();
      // read and write together
      cyc(1'b1, 1'b1, 1'b1, waddr(3), 32'h5555_5555, 1'b0);
      idle();
      rd(3);

      // read counter saturation
      rst_cyc();
      for (int k = 0; k < CNT_MAX + 4; k++) rd(1);
      check_eq("rd_sat", {24'h0, rd_count}, CNT_MAX);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dm_responder.md
DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit data-memory words (power of two).
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the access counters.
REQ-003 SHALL use one clock; reset is synchronous and active-high: clk  input  1  rising-edge clock shared with the CPU pipeline.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 DM_CS  input  1  data-memory chip select from the CPU M stage.
REQ-006 DM_R  input  1  read strobe, valid only with DM_CS.
REQ-007 DM_W  input  1  write strobe, valid only with DM_CS.
REQ-008 maddr  input  32  byte address from the CPU.
REQ-009 mwdata  input  32  store data from the CPU.
REQ-010 mr_data  output  32  load data returned to the CPU in the same cycle.
REQ-011 err  output  1  sticky protocol/address error flag.
REQ-012 rd_count  output  CNT_W  count of accepted reads.
REQ-013 wr_count  output  CNT_W  count of accepted writes.

Function
REQ-014 Word index SHALL be maddr[log2(DEPTH_WORDS)+1:2]; in-range SHALL mean all maddr bits above that field are 0.
REQ-015 Valid read SHALL be DM_CS & DM_R & ~DM_W & in-range; valid write SHALL be DM_CS & DM_W & ~DM_R & in-range.
REQ-016 mr_data SHALL be combinational, zero latency: on a valid read it SHALL be the write-buffer data if the buffer is PENDING with a matching index, otherwise the RAM word; in every other case it SHALL be 32'h0.
REQ-017 Writes SHALL be posted into a one-entry write buffer (index, data) at the rising edge on which the valid write is sampled; the RAM SHALL be updated one edge later (drain).
REQ-018 Write-buffer FSM states SHALL be EMPTY and PENDING: EMPTY+write->PENDING; PENDING+write->PENDING (drain old entry to RAM and capture new entry on the same edge); PENDING+no write->EMPTY (drain); EMPTY+no write->EMPTY.
REQ-019 Back-to-back writes to the same index SHALL leave the last written data in RAM after draining.
REQ-020 A read in the same cycle as a new write SHALL NOT see the new write's data; it SHALL see only the previously buffered entry or RAM.
REQ-021 maddr[1:0] != 0 on a DM_CS access SHALL set err; the access SHALL proceed with the low two bits ignored.
REQ-022 An out-of-range access, or DM_CS with DM_R and DM_W both high, SHALL set err, return 32'h0, leave RAM and buffer unchanged, and increment no counter.
REQ-023 rd_count and wr_count SHALL increment by 1 per valid access and saturate at all-ones.
REQ-024 DM_R or DM_W without DM_CS SHALL be ignored and SHALL NOT set err.

Reset
REQ-025 Reset SHALL force the buffer FSM to EMPTY, err=0, rd_count=0, wr_count=0; mr_data SHALL be 32'h0 while reset is high.
REQ-026 A PENDING entry present at reset SHALL be discarded, not drained; RAM contents SHALL NOT be cleared by reset.
REQ-027 Accesses sampled while reset is high SHALL be ignored.

Structure
REQ-028 Package dm_pkg SHALL hold DEPTH_WORDS/CNT_W defaults, the derived index width, and the EMPTY/PENDING state enum.
REQ-029 The write buffer plus its forwarding compare SHALL be a sub-module named dm_wbuf; RAM array, range/error checks, and counters SHALL stay in dm_responder.

Verification
REQ-030 Write 0x1000_0004<-0xDEADBEEF... (out of range) -> err=1, wr_count unchanged, subsequent read of index 1 returns the prior value.
REQ-031 Write idx 3 <- 0xA5A5A5A5, read idx 3 on the next cycle -> mr_data=0xA5A5A5A5 forwarded from buffer; read again two cycles later -> 0xA5A5A5A5 from RAM.
REQ-032 Writes idx 5 <- 1, 2, 3 on consecutive cycles, then idle -> RAM idx 5 = 3, FSM EMPTY, wr_count=3.
REQ-033 Write idx 7 <- 0x1234, assert reset on the next edge -> read idx 7 returns old contents, counters 0, err 0.
REQ-034 Read with maddr=0x0000_0006 -> err=1, mr_data = word at idx 1, rd_count+1; DM_CS=1 with DM_R=DM_W=1 -> mr_data=0, err=1, counters unchanged.
REQ-035 Issue 2^CNT_W+3 reads -> rd_count holds at all-ones.
